// File: rtl/xadc_pkg.sv
// Shared XADC DRP arbiter definitions: FSM encoding, DRP widths, timeout readback value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xadc_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;
  localparam int CH_W   = 5;
  localparam int SMP_W  = 12;

  localparam logic [DRP_DW-1:0] TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AUTO = 2'd1,
    ST_SW   = 2'd2
  } state_t;

  // Status/result registers of the XADC sit at DRP address == channel number.
  function automatic logic [DRP_AW-1:0] auto_addr(input logic [CH_W-1:0] ch);
    return {2'b00, ch};
  endfunction

endpackage

// File: rtl/xadc_drp_arbiter.sv
// Arbitrates the XADC DRP between EOC-triggered result readback and a software access port.
// Latency: DEN one cycle after a pending request is seen in IDLE; ack/sample one cycle after DRDY.
// Backpressure: one request of each kind is held; extra EOC overwrites (ovr_o), extra SW request is dropped.
// Ports: clk_i/rstn_i; eoc_i/channel_i from XADC; sw_* request/ack port; drp_* DRP master;
//        smp_* auto-readback sample; busy_o transaction in flight; ovr_o EOC overrun pulse.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              eoc_i,
  input  logic [CH_W-1:0]   channel_i,
  input  logic              sw_req_i,
  input  logic              sw_we_i,
  input  logic [DRP_AW-1:0] sw_addr_i,
  input  logic [DRP_DW-1:0] sw_wdata_i,
  output logic              sw_ack_o,
  output logic [DRP_DW-1:0] sw_rdata_o,
  output logic              sw_err_o,
  output logic              drp_den_o,
  output logic              drp_dwe_o,
  output logic [DRP_AW-1:0] drp_daddr_o,
  output logic [DRP_DW-1:0] drp_di_o,
  input  logic [DRP_DW-1:0] drp_do_i,
  input  logic              drp_drdy_i,
  output logic              smp_vld_o,
  output logic [CH_W-1:0]   smp_ch_o,
  output logic [SMP_W-1:0]  smp_data_o,
  output logic              busy_o,
  output logic              ovr_o
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                auto_pend_q, auto_pend_d;
  logic [CH_W-1:0]     auto_ch_q, auto_ch_d;
  logic [CH_W-1:0]     gnt_ch_q, gnt_ch_d;
  logic                sw_pend_q, sw_pend_d;
  logic                sw_we_q, sw_we_d;
  logic [DRP_AW-1:0]   sw_addr_q, sw_addr_d;
  logic [DRP_DW-1:0]   sw_wdata_q, sw_wdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                den_d, dwe_d, smp_vld_d, ack_d, err_d, busy_d, ovr_d;
  logic [DRP_AW-1:0]   daddr_d;
  logic [DRP_DW-1:0]   di_d, rdata_d;
  logic [CH_W-1:0]     smp_ch_d;
  logic [SMP_W-1:0]    smp_data_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      auto_pend_q <= 1'b0;
      auto_ch_q   <= '0;
      gnt_ch_q    <= '0;
      sw_pend_q   <= 1'b0;
      sw_we_q     <= 1'b0;
      sw_addr_q   <= '0;
      sw_wdata_q  <= '0;
      cnt_q       <= '0;
      drp_den_o   <= 1'b0;
      drp_dwe_o   <= 1'b0;
      drp_daddr_o <= '0;
      drp_di_o    <= '0;
      smp_vld_o   <= 1'b0;
      smp_ch_o    <= '0;
      smp_data_o  <= '0;
      sw_ack_o    <= 1'b0;
      sw_rdata_o  <= '0;
      sw_err_o    <= 1'b0;
      busy_o      <= 1'b0;
      ovr_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= auto_pend_d;
      auto_ch_q   <= auto_ch_d;
      gnt_ch_q    <= gnt_ch_d;
      sw_pend_q   <= sw_pend_d;
      sw_we_q     <= sw_we_d;
      sw_addr_q   <= sw_addr_d;
      sw_wdata_q  <= sw_wdata_d;
      cnt_q       <= cnt_d;
      drp_den_o   <= den_d;
      drp_dwe_o   <= dwe_d;
      drp_daddr_o <= daddr_d;
      drp_di_o    <= di_d;
      smp_vld_o   <= smp_vld_d;
      smp_ch_o    <= smp_ch_d;
      smp_data_o  <= smp_data_d;
      sw_ack_o    <= ack_d;
      sw_rdata_o  <= rdata_d;
      sw_err_o    <= err_d;
      busy_o      <= busy_d;
      ovr_o       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    auto_pend_d = auto_pend_q;
    auto_ch_d   = auto_ch_q;
    gnt_ch_d    = gnt_ch_q;
    sw_pend_d   = sw_pend_q;
    sw_we_d     = sw_we_q;
    sw_addr_d   = sw_addr_q;
    sw_wdata_d  = sw_wdata_q;
    cnt_d       = cnt_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    daddr_d     = '0;
    di_d        = '0;
    smp_vld_d   = 1'b0;
    smp_ch_d    = '0;
    smp_data_d  = '0;
    ack_d       = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    ovr_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Fixed priority: result readback must not be starved by software.
        if (auto_pend_q) begin
          den_d       = 1'b1;
          daddr_d     = auto_addr(auto_ch_q);
          gnt_ch_d    = auto_ch_q;
          auto_pend_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_AUTO;
        end else if (sw_pend_q) begin
          den_d     = 1'b1;
          dwe_d     = sw_we_q;
          daddr_d   = sw_addr_q;
          di_d      = sw_wdata_q;
          sw_pend_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SW;
        end
      end
      ST_AUTO: begin
        if (drp_drdy_i) begin
          smp_vld_d  = 1'b1;
          smp_ch_d   = gnt_ch_q;
          smp_data_d = drp_do_i[DRP_DW-1:4];
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SW: begin
        // The SW request latch cannot change while in SW, so sw_we_q still describes this access.
        if (drp_drdy_i) begin
          ack_d   = 1'b1;
          rdata_d = sw_we_q ? '0 : drp_do_i;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = TIMEOUT_RDATA;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new EOC wins over a same-cycle grant clear; overrun is judged on the pre-edge pending bit.
    if (eoc_i) begin
      ovr_d       = auto_pend_q;
      auto_pend_d = 1'b1;
      auto_ch_d   = channel_i;
    end

    if (sw_req_i && !sw_pend_q && (state_q != ST_SW)) begin
      sw_pend_d  = 1'b1;
      sw_we_d    = sw_we_i;
      sw_addr_d  = sw_addr_i;
      sw_wdata_d = sw_wdata_i;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: directed scenarios plus random EOC/SW traffic against a transaction model.
// Latency: n/a.
// Backpressure: the bench acts as a DRP slave with scheduled, random or absent DRDY.
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        eoc_i = 1'b0;
  logic [4:0]  channel_i = '0;
  logic        sw_req_i = 1'b0;
  logic        sw_we_i = 1'b0;
  logic [6:0]  sw_addr_i = '0;
  logic [15:0] sw_wdata_i = '0;
  logic        sw_ack_o;
  logic [15:0] sw_rdata_o;
  logic        sw_err_o;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i = '0;
  logic        drp_drdy_i = 1'b0;
  logic        smp_vld_o;
  logic [4:0]  smp_ch_o;
  logic [11:0] smp_data_o;
  logic        busy_o;
  logic        ovr_o;

  always #5 clk_i = ~clk_i;

  xadc_drp_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .eoc_i(eoc_i), .channel_i(channel_i),
    .sw_req_i(sw_req_i), .sw_we_i(sw_we_i), .sw_addr_i(sw_addr_i), .sw_wdata_i(sw_wdata_i),
    .sw_ack_o(sw_ack_o), .sw_rdata_o(sw_rdata_o), .sw_err_o(sw_err_o),
    .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o), .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o),
    .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i),
    .smp_vld_o(smp_vld_o), .smp_ch_o(smp_ch_o), .smp_data_o(smp_data_o),
    .busy_o(busy_o), .ovr_o(ovr_o)
  );

  int checks = 0;
  int failures = 0;
  int t = 0;
  int ack_seen = 0;
  int ovr_seen = 0;

  // Transaction-level model: pending requests, the one outstanding access and when it was issued.
  bit          m_apend, m_spend, m_swe, m_gwe;
  logic [4:0]  m_ach, m_gch;
  logic [6:0]  m_saddr;
  logic [15:0] m_swdata;
  int          m_txn;     // 0 none, 1 auto readback, 2 software access
  int          m_den_t;

  logic        e_den, e_dwe, e_smp, e_ack, e_err, e_busy, e_ovr;
  logic [6:0]  e_daddr;
  logic [15:0] e_di, e_rdata;
  logic [4:0]  e_sch;
  logic [11:0] e_sdata;

  // DRP slave behaviour
  bit          rnd_slave = 1'b0;
  int          slave_lat = 2;
  logic [15:0] slave_data = 16'h0;
  int          resp_t = -1;
  logic [15:0] resp_d = 16'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    m_apend = 0; m_spend = 0; m_swe = 0; m_gwe = 0;
    m_ach = '0; m_gch = '0; m_saddr = '0; m_swdata = '0;
    m_txn = 0; m_den_t = 0;
  endtask

  // Applies the inputs consumed at the clock edge that produced sample t.
  task automatic model_edge();
    bit old_apend, old_spend;
    int old_txn;
    old_apend = m_apend; old_spend = m_spend; old_txn = m_txn;
    e_den = 0; e_dwe = 0; e_daddr = '0; e_di = '0; e_smp = 0; e_sch = '0; e_sdata = '0;
    e_ack = 0; e_rdata = '0; e_err = 0; e_ovr = 0;
    if (m_txn == 0) begin
      if (m_apend) begin
        e_den = 1; e_daddr = {2'b00, m_ach}; m_gch = m_ach; m_apend = 0; m_txn = 1; m_den_t = t;
      end else if (m_spend) begin
        e_den = 1; e_dwe = m_swe; e_daddr = m_saddr; e_di = m_swdata;
        m_gwe = m_swe; m_spend = 0; m_txn = 2; m_den_t = t;
      end
    end else if (drp_drdy_i) begin
      if (m_txn == 1) begin
        e_smp = 1; e_sch = m_gch; e_sdata = drp_do_i[15:4];
      end else begin
        e_ack = 1; e_rdata = m_gwe ? 16'h0 : drp_do_i;
      end
      m_txn = 0;
    end else if (t - m_den_t == TO) begin
      if (m_txn == 2) begin
        e_ack = 1; e_err = 1; e_rdata = 16'hDEAD;
      end
      m_txn = 0;
    end
    if (eoc_i) begin
      e_ovr = old_apend; m_apend = 1; m_ach = channel_i;
    end
    if (sw_req_i && !old_spend && old_txn != 2) begin
      m_spend = 1; m_swe = sw_we_i; m_saddr = sw_addr_i; m_swdata = sw_wdata_i;
    end
    e_busy = (m_txn != 0);
  endtask

  task automatic cycle();
    int lat;
    @(negedge clk_i);
    t++;
    model_edge();
    chk("den", drp_den_o, e_den);
    chk("dwe", drp_dwe_o, e_dwe);
    chk("daddr", drp_daddr_o, e_daddr);
    chk("di", drp_di_o, e_di);
    chk("smp_vld", smp_vld_o, e_smp);
    chk("smp_ch", smp_ch_o, e_sch);
    chk("smp_data", smp_data_o, e_sdata);
    chk("sw_ack", sw_ack_o, e_ack);
    chk("sw_rdata", sw_rdata_o, e_rdata);
    chk("sw_err", sw_err_o, e_err);
    chk("busy", busy_o, e_busy);
    chk("ovr", ovr_o, e_ovr);
    if (sw_ack_o) ack_seen++;
    if (ovr_o) ovr_seen++;
    eoc_i = 0; sw_req_i = 0; drp_drdy_i = 0; drp_do_i = 16'($urandom);
    if (e_den) begin
      if (rnd_slave) lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 6));
      else lat = slave_lat;
      resp_t = (lat < 0) ? -1 : t + lat;
      resp_d = rnd_slave ? 16'($urandom) : slave_data;
    end
    if (t == resp_t) begin
      drp_drdy_i = 1; drp_do_i = resp_d;
    end else if (rnd_slave && m_txn == 0 && $urandom_range(0, 15) == 0) begin
      drp_drdy_i = 1;
    end
  endtask

  task automatic run_until(input int kind, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if ((kind == 0 && drp_den_o) || (kind == 1 && smp_vld_o) || (kind == 2 && sw_ack_o)) begin
        when = t;
        return;
      end
    end
    chk($sformatf("wait_kind%0d_expired", kind), 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o, smp_vld_o, smp_ch_o, smp_data_o,
            sw_ack_o, sw_rdata_o, sw_err_o, busy_o, ovr_o};
  endfunction

  task automatic sw_req(input logic we, input logic [6:0] addr, input logic [15:0] wd);
    sw_req_i = 1; sw_we_i = we; sw_addr_i = addr; sw_wdata_i = wd;
  endtask

  int td, ts, ta, o0, a0;

  initial begin
    model_reset();
    repeat (2) begin @(negedge clk_i); t++; end
    chk("reset_outs", all_outs(), 64'd0);
    rstn_i = 1;
    repeat (3) cycle();

    // Auto readback of channel 16, DRDY four cycles after DEN.
    slave_lat = 4; slave_data = 16'hABC0;
    eoc_i = 1; channel_i = 5'd16;
    run_until(0, 6, td);
    chk("auto_addr", drp_daddr_o, 7'd16);
    run_until(1, 10, ts);
    chk("auto_smp_ch", smp_ch_o, 5'd16);
    chk("auto_smp_data", smp_data_o, 12'hABC);
    chk("auto_lat", ts - td, 5);
    repeat (3) cycle();

    // Simultaneous SW read and EOC: auto first, SW DEN one cycle after the sample.
    slave_lat = 3; slave_data = 16'h5A5A;
    eoc_i = 1; channel_i = 5'd24; sw_req(1'b0, 7'h00, 16'h0);
    run_until(0, 6, td);
    chk("prio_auto_addr", drp_daddr_o, 7'd24);
    run_until(1, 10, ts);
    run_until(0, 4, td);
    chk("prio_sw_gap", td - ts, 1);
    chk("prio_sw_addr", drp_daddr_o, 7'h00);
    run_until(2, 10, ta);
    chk("prio_sw_rdata", sw_rdata_o, 16'h5A5A);
    repeat (3) cycle();

    // SW write.
    slave_lat = 2; slave_data = 16'hFFFF;
    sw_req(1'b1, 7'h41, 16'h2F0F);
    run_until(0, 6, td);
    chk("wr_dwe", drp_dwe_o, 1'b1);
    chk("wr_di", drp_di_o, 16'h2F0F);
    chk("wr_addr", drp_daddr_o, 7'h41);
    run_until(2, 10, ta);
    chk("wr_rdata", sw_rdata_o, 16'h0);
    chk("wr_err", sw_err_o, 1'b0);
    repeat (3) cycle();

    // SW read timeout.
    slave_lat = -1;
    sw_req(1'b0, 7'h05, 16'h0);
    run_until(0, 6, td);
    run_until(2, TO + 6, ta);
    chk("to_lat", ta - td, TO);
    chk("to_err", sw_err_o, 1'b1);
    chk("to_rdata", sw_rdata_o, 16'hDEAD);
    chk("to_busy", busy_o, 1'b0);
    repeat (3) cycle();

    // Three EOCs during one auto access: two overruns, last channel wins.
    slave_lat = 8; slave_data = 16'h1230;
    o0 = ovr_seen;
    eoc_i = 1; channel_i = 5'd9;
    run_until(0, 6, td);
    eoc_i = 1; channel_i = 5'd1; cycle();
    eoc_i = 1; channel_i = 5'd2; cycle();
    eoc_i = 1; channel_i = 5'd3; cycle();
    run_until(1, 12, ts);
    chk("ovr_count", ovr_seen - o0, 2);
    run_until(0, 4, td);
    chk("ovr_next_addr", drp_daddr_o, 7'd3);
    run_until(1, 12, ts);
    repeat (3) cycle();

    // EOC in the same cycle as DRDY of the running auto access.
    slave_lat = 3; slave_data = 16'h7770;
    o0 = ovr_seen;
    eoc_i = 1; channel_i = 5'd5;
    run_until(0, 6, td);
    cycle(); cycle(); cycle();
    eoc_i = 1; channel_i = 5'd7;
    cycle();
    chk("same_smp", smp_vld_o, 1'b1);
    chk("same_ovr", ovr_seen - o0, 0);
    run_until(0, 4, td);
    chk("same_next_addr", drp_daddr_o, 7'd7);
    run_until(1, 10, ts);
    repeat (3) cycle();

    // Reset during SW wait; DRDY arrives after release.
    slave_lat = 8; slave_data = 16'h4444;
    sw_req(1'b0, 7'h10, 16'h0);
    run_until(0, 6, td);
    repeat (3) cycle();
    a0 = ack_seen;
    rstn_i = 0;
    #1;
    chk("midrst_outs", all_outs(), 64'd0);
    repeat (2) begin @(negedge clk_i); t++; end
    rstn_i = 1;
    model_reset();
    repeat (10) cycle();
    chk("midrst_no_ack", ack_seen - a0, 0);
    chk("midrst_busy", busy_o, 1'b0);

    // Random traffic.
    rnd_slave = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        eoc_i = 1; channel_i = 5'($urandom);
      end
      if ($urandom_range(0, 9) == 0) sw_req(1'($urandom), 7'($urandom), 16'($urandom));
      cycle();
    end
    rnd_slave = 0; slave_lat = 1;
    repeat (2 * TO + 10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning DRDY wait limit in clk_i cycles (legal range 4..255).
REQ-002 SHALL have ports: clk_i  in  1  clock for DRP and all logic.
REQ-003 rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-004 eoc_i  in  1  XADC end-of-conversion pulse; channel_i  in  5  XADC channel valid with eoc_i.
REQ-005 sw_req_i  in  1  SW request strobe; sw_we_i  in  1  write (1) / read (0); sw_addr_i  in  7  DRP address; sw_wdata_i  in  16  write data.
REQ-006 sw_ack_o  out  1  SW completion pulse; sw_rdata_o  out  16  read data, valid with sw_ack_o; sw_err_o  out  1  timeout flag, valid with sw_ack_o.
REQ-007 drp_den_o  out  1; drp_dwe_o  out  1; drp_daddr_o  out  7; drp_di_o  out  16; drp_do_i  in  16; drp_drdy_i  in  1  XADC DRP port.
REQ-008 smp_vld_o  out  1  sample pulse; smp_ch_o  out  5  channel; smp_data_o  out  12  result = DRP data[15:4].
REQ-009 busy_o  out  1  transaction in flight; ovr_o  out  1  single-cycle EOC-overrun pulse.

Function
REQ-010 FSM states SHALL be IDLE, AUTO (auto-readback waiting DRDY) and SW (SW access waiting DRDY).
REQ-011 eoc_i SHALL set an auto-pending bit and latch channel_i, in any state.
REQ-012 sw_req_i SHALL latch we/addr/wdata and set a SW-pending bit; sw_req_i while SW-pending or in SW SHALL be ignored.
REQ-013 In IDLE, auto-pending SHALL win over SW-pending (fixed priority); the grant cycle issues drp_den_o=1 for exactly one cycle.
REQ-014 Auto grant: drp_daddr_o={2'b00,latched channel}, drp_dwe_o=0, drp_di_o=0; auto-pending cleared; state -> AUTO.
REQ-015 SW grant: drp_daddr_o, drp_dwe_o, drp_di_o from latched SW request; SW-pending cleared; state -> SW.
REQ-016 drp_den_o SHALL never assert outside IDLE; at most one DRP transaction outstanding.
REQ-017 drp_drdy_i in AUTO SHALL produce smp_vld_o=1 next cycle with smp_ch_o = granted channel, smp_data_o = drp_do_i[15:4]; state -> IDLE.
REQ-018 drp_drdy_i in SW SHALL produce sw_ack_o=1 next cycle with sw_rdata_o=drp_do_i (0 for writes), sw_err_o=0; state -> IDLE.
REQ-019 A timeout counter SHALL clear on grant and increment in AUTO/SW; reaching TIMEOUT-1 without DRDY SHALL return to IDLE.
REQ-020 Timeout in SW SHALL pulse sw_ack_o with sw_err_o=1, sw_rdata_o=16'hDEAD; timeout in AUTO SHALL silently drop the sample.
REQ-021 drp_drdy_i in IDLE SHALL be ignored.
REQ-022 eoc_i while auto-pending already set SHALL overwrite latched channel and pulse ovr_o next cycle.
REQ-023 eoc_i and DRDY of the prior AUTO transaction in the same cycle SHALL both take effect (sample emitted, new pending set, no ovr_o).
REQ-024 Earliest re-grant SHALL be the cycle after return to IDLE; IDLE-to-IDLE turnaround = one cycle.
REQ-025 busy_o SHALL be 1 in AUTO and SW, else 0.
REQ-026 sw_ack_o, smp_vld_o, ovr_o, drp_den_o SHALL be single-cycle pulses, all registered.

Reset
REQ-027 rstn_i low SHALL asynchronously force IDLE, clear both pending bits, counter, and all outputs to 0.
REQ-028 Reset mid-transaction SHALL abandon it with no ack or sample; a late DRDY after reset SHALL be ignored per REQ-021.

Structure
REQ-029 State encoding, DRP address width 7, data width 16 and timeout read value 16'hDEAD SHALL live in shared package xadc_pkg.
REQ-030 The block SHALL be flat, with no sub-modules; timeout counter width $clog2(TIMEOUT).

Verification
REQ-031 eoc_i with channel_i=16, DRDY 4 cycles after DEN with drp_do_i=16'hABC0 -> smp_vld_o pulse, smp_ch_o=16, smp_data_o=12'hABC.
REQ-032 SW read addr 7'h00 and eoc_i channel 24 in same cycle -> auto granted first, SW DEN exactly one cycle after auto DRDY handling, sw_rdata_o = returned data.
REQ-033 SW write addr 7'h41 data 16'h2F0F -> DEN with DWE=1, DI=16'h2F0F; DRDY -> sw_ack_o, sw_rdata_o=0, sw_err_o=0.
REQ-034 SW read, no DRDY -> sw_ack_o with sw_err_o=1, sw_rdata_o=16'hDEAD exactly TIMEOUT cycles after DEN; FSM in IDLE.
REQ-035 Three eoc_i (ch 1, 2, 3) during one AUTO transaction -> two ovr_o pulses; next grant uses channel 3.
REQ-036 rstn_i low during SW wait, then DRDY after release -> no sw_ack_o, busy_o=0, outputs zero.
